// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants, control width and the request/response
// payload structs used between the arbiter and the shared ALU.
package alu_pkg;

    localparam int ALU_CTRL_W = 4;
    localparam int ALU_OP_MAX = 9;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'd3;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'd4;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'd5;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'd6;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'd7;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'd8;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'd9;

    typedef struct packed {
        logic [31:0]           a;
        logic [31:0]           b;
        logic [ALU_CTRL_W-1:0] ctrl;
    } alu_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic        illegal;
    } alu_rsp_t;

    // Op codes above ALU_OP_MAX are issued but flagged.
    function automatic logic ctrl_is_illegal(input logic [ALU_CTRL_W-1:0] ctrl);
        return (ctrl > ALU_CTRL_W'(ALU_OP_MAX));
    endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU; unknown op codes yield zero with the illegal flag set.
module alu
    import alu_pkg::*;
(
    input  alu_req_t req,
    output alu_rsp_t rsp
);

    logic [4:0] shamt_s;

    assign shamt_s = req.b[4:0];

    // Result select by op code.
    always_comb begin
        rsp.data    = 32'd0;
        rsp.illegal = ctrl_is_illegal(req.ctrl);
        case (req.ctrl)
            ALU_ADD:  rsp.data = req.a + req.b;
            ALU_SUB:  rsp.data = req.a - req.b;
            ALU_SLL:  rsp.data = req.a << shamt_s;
            ALU_SRA:  rsp.data = $signed(req.a) >>> shamt_s;
            ALU_SRL:  rsp.data = req.a >> shamt_s;
            ALU_OR:   rsp.data = req.a | req.b;
            ALU_XOR:  rsp.data = req.a ^ req.b;
            ALU_SLT:  rsp.data = ($signed(req.a) < $signed(req.b)) ? 32'd1 : 32'd0;
            ALU_SLTU: rsp.data = (req.a < req.b) ? 32'd1 : 32'd0;
            ALU_AND:  rsp.data = req.a & req.b;
            default:  rsp.data = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Rotating-priority picker: grants the first set request at or after ptr, modulo NUM_REQ.
// A ptr tied to zero turns it into a fixed lowest-index-wins arbiter.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    // Walk the requesters starting at ptr and stop at the first valid one.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end else begin
                j = j;
            end
            if (!grant_any && req[j]) begin
                grant_any = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = ID_W'(j);
            end else begin
                grant_any = grant_any;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters with a single-entry registered response stage.
// Define ALU_ARB_RR_EN for round-robin grant; otherwise the lowest valid index always wins.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][31:0]             req_a,
    input  logic [NUM_REQ-1:0][31:0]             req_b,
    input  logic [NUM_REQ-1:0][ALU_CTRL_W-1:0]   req_ctrl,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [ID_W-1:0]                      rsp_id,
    output logic [31:0]                          rsp_data,
    output logic                                 rsp_illegal,
    output logic [31:0]                          op_count
);

    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic               grant_any_s;
    logic [ID_W-1:0]    rr_ptr_s;
    logic               free_s;
    logic               accept_s;
    alu_req_t           sel_req_s;
    alu_rsp_t           alu_rsp_s;

    alu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // The slot accepts when empty or being drained this cycle; nothing is offered in reset.
    assign free_s    = !rsp_valid || rsp_ready;
    assign accept_s  = free_s && grant_any_s && rst_n;
    assign req_ready = (free_s && rst_n) ? grant_s : '0;

`ifdef ALU_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr_r;

    // Pointer moves to just past the winner, and only when something is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (accept_s) begin
            rr_ptr_r <= (grant_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + ID_W'(1'b1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign rr_ptr_s = rr_ptr_r;
`else
    assign rr_ptr_s = '0;
`endif

    assign sel_req_s.a    = req_a[grant_idx_s];
    assign sel_req_s.b    = req_b[grant_idx_s];
    assign sel_req_s.ctrl = req_ctrl[grant_idx_s];

    alu u_alu (
        .req (sel_req_s),
        .rsp (alu_rsp_s)
    );

    // Response stage: load on accept, drop valid when drained with nothing behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_data    <= 32'd0;
            rsp_id      <= '0;
            rsp_illegal <= 1'b0;
        end else if (accept_s) begin
            rsp_valid   <= 1'b1;
            rsp_data    <= alu_rsp_s.data;
            rsp_id      <= grant_idx_s;
            rsp_illegal <= alu_rsp_s.illegal;
        end else if (free_s) begin
            rsp_valid   <= 1'b0;
        end else begin
            rsp_valid   <= rsp_valid;
        end
    end

    // Accepted-op counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= 32'd0;
        end else if (accept_s) begin
            op_count <= op_count + 32'd1;
        end else begin
            op_count <= op_count;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed literal cases plus randomized traffic
// compared every cycle against a behavioural model of arbitration and the ALU.
module tb_alu_arbiter;

    localparam int N = 4;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req_valid;
    logic [N-1:0][31:0]   req_a;
    logic [N-1:0][31:0]   req_b;
    logic [N-1:0][3:0]    req_ctrl;
    logic [N-1:0]         req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    logic [31:0]          rsp_data;
    logic                 rsp_illegal;
    logic [31:0]          op_count;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    logic        m_valid;
    logic [31:0] m_data;
    int          m_id;
    logic        m_ill;
    logic [31:0] m_count;
    int          m_ptr;
    logic [N-1:0] acc_vec = '0;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ctrl    (req_ctrl),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_illegal (rsp_illegal),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        logic [31:0] r;
        logic        ill;
        int          sh;
        r   = 32'd0;
        ill = 1'b0;
        sh  = int'(b % 32);
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a << sh;
            4'd3: r = $signed(a) >>> sh;
            4'd4: r = a >> sh;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: r = (a < b) ? 32'd1 : 32'd0;
            4'd9: r = a & b;
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Per-cycle compare against the model, then advance the model by this cycle's accept.
    always @(negedge clk) begin : cmp
        int g;
        logic free;
        logic [N-1:0] er;
        logic [32:0] res;
        if (!rst_n) begin
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_op_count", op_count, 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_data", rsp_data, 32'd0);
            chk("rst_rsp_id", 32'(rsp_id), 32'd0);
            m_valid <= 1'b0;
            m_data  <= 32'd0;
            m_id    <= 0;
            m_ill   <= 1'b0;
            m_count <= 32'd0;
            m_ptr   <= 0;
            acc_vec <= '0;
        end else begin
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_illegal", 32'(rsp_illegal), 32'(m_ill));
            chk("op_count", op_count, m_count);
            free = !m_valid || rsp_ready;
            g = pick(req_valid, RR ? m_ptr : 0);
            er = (free && g >= 0) ? (N'(1) << g) : '0;
            chk("req_ready", 32'(req_ready), 32'(er));
            acc_vec <= er;
            if (er != '0) begin
                res = ref_alu(req_a[g], req_b[g], req_ctrl[g]);
                m_valid <= 1'b1;
                m_data  <= res[31:0];
                m_ill   <= res[32];
                m_id    <= g;
                m_count <= m_count + 32'd1;
                m_ptr   <= (g + 1) % N;
            end else if (free) begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
        @(posedge clk); #1;
        req_valid      = '0;
        req_valid[idx] = 1'b1;
        req_a[idx]     = a;
        req_b[idx]     = b;
        req_ctrl[idx]  = op;
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    initial begin
        logic [31:0] held_data;
        logic [1:0]  held_id;
        req_valid = 4'b1010;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_op_count", op_count, 32'd0);
        req_valid = '0;
        rst_n = 1'b1;

        // single request: 5 - 3 from requester 2
        issue(2, 32'd5, 32'd3, 4'd1);
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_data", rsp_data, 32'd2);
        chk("single_id", 32'(rsp_id), 32'd2);
        chk("single_count", op_count, 32'd1);

        issue(1, 32'hFFFF_FFFF, 32'd7, 4'd12);
        chk("illegal_data", rsp_data, 32'd0);
        chk("illegal_flag", 32'(rsp_illegal), 32'd1);
        chk("illegal_id", 32'(rsp_id), 32'd1);

        issue(0, 32'h8000_0000, 32'd4, 4'd3);
        chk("sra_data", rsp_data, 32'hF800_0000);

        issue(3, 32'h8000_0000, 32'd1, 4'd7);
        chk("slt_data", rsp_data, 32'd1);
        chk("slt_flag", 32'(rsp_illegal), 32'd0);
        chk("slt_count", op_count, 32'd4);

        // backpressure with all four requesters waiting
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[i]    = 32'(i + 10);
            req_b[i]    = 32'(i);
            req_ctrl[i] = 4'd0;
        end
        req_valid = 4'b1111;
        held_data = rsp_data;
        held_id   = rsp_id;
        #1;
        chk("bp_req_ready", 32'(req_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_data_hold", rsp_data, held_data);
            chk("bp_id_hold", 32'(rsp_id), 32'(held_id));
            chk("bp_count_hold", op_count, 32'd4);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp_pop_id", 32'(rsp_id), 32'd0);
        chk("bp_pop_data", rsp_data, 32'd10);
        chk("bp_pop_count", op_count, 32'd5);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            chk("stream_valid", 32'(rsp_valid), 32'd1);
            chk("stream_id", 32'(rsp_id), RR ? 32'(k % N) : 32'd0);
            chk("stream_data", rsp_data, RR ? 32'(2 * (k % N) + 10) : 32'd10);
        end
        chk("stream_count", op_count, 32'd12);

        // requesters 1 and 3 contend
        req_valid = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("pair_id", 32'(rsp_id), (RR && (k % 2 == 1)) ? 32'd3 : 32'd1);
        end

        // asynchronous reset mid-stream
        req_valid = 4'b1110;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_count", op_count, 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = '0;
        chk("post_rst_id", 32'(rsp_id), 32'd1);
        chk("post_rst_count", op_count, 32'd1);

        // randomized traffic honoring the hold-until-accepted rule
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !acc_vec[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_a[i]     = $urandom;
                    req_b[i]     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                    req_ctrl[i]  = 4'($urandom_range(0, 15));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
